// File: rtl/wb_dsp_master_interface.sv
// Wishbone classic-cycle initiator for the DSP engine.
// Runs one single-word Wishbone cycle per start/done command. The cycle
// terminates on ack, err, exhausted retries or timeout, and a status code
// is reported alongside the one-cycle done pulse.
module wb_dsp_master_interface #(
  parameter int dw        = 32,
  parameter int aw        = 8,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3,
  parameter int RETRY_GAP = 2
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          cmd_start,
  input  logic          cmd_we,
  input  logic [aw-1:0] cmd_adr,
  input  logic [dw-1:0] cmd_dat,
  input  logic [3:0]    cmd_sel,
  output logic          cmd_busy,
  output logic          cmd_done,
  output logic [dw-1:0] cmd_rdata,
  output logic [1:0]    cmd_status,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_BUS     = 2'b01;
  localparam logic [1:0] ST_BACKOFF = 2'b10;

  localparam logic [1:0] STS_OK  = 2'b00;
  localparam logic [1:0] STS_ERR = 2'b01;
  localparam logic [1:0] STS_RTY = 2'b10;
  localparam logic [1:0] STS_TMO = 2'b11;

  // Last stb cycle of an attempt, retry ceiling and last backoff cycle.
  localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 1);
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);
  localparam logic [3:0] GAP_LAST    = 4'(RETRY_GAP - 1);

  logic [1:0] state_r;
  logic [3:0] retry_cnt_r;
  logic [7:0] tmo_cnt_r;
  logic [3:0] gap_cnt_r;

  logic       term_s;
  logic       backoff_s;
  logic [1:0] term_status_s;

  // Classic single cycles only: no burst signalling.
  assign wb_cti_o = 3'b000;
  assign wb_bte_o = 2'b00;

  // Decode the terminating condition of the current BUS edge (ack > err > rty > timeout).
  always_comb begin
    term_s        = 1'b0;
    backoff_s     = 1'b0;
    term_status_s = STS_OK;
    if (state_r == ST_BUS) begin
      if (wb_ack_i) begin
        term_s        = 1'b1;
        term_status_s = STS_OK;
      end else if (wb_err_i) begin
        term_s        = 1'b1;
        term_status_s = STS_ERR;
      end else if (wb_rty_i) begin
        if (retry_cnt_r < RETRY_LIMIT) begin
          backoff_s = 1'b1;
        end else begin
          term_s        = 1'b1;
          term_status_s = STS_RTY;
        end
      end else if (tmo_cnt_r == TMO_LAST) begin
        term_s        = 1'b1;
        term_status_s = STS_TMO;
      end else begin
        term_s = 1'b0;
      end
    end else begin
      term_s = 1'b0;
    end
  end

  // Command FSM, Wishbone outputs and completion reporting.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_r     <= ST_IDLE;
      retry_cnt_r <= 4'd0;
      tmo_cnt_r   <= 8'd0;
      gap_cnt_r   <= 4'd0;
      cmd_busy    <= 1'b0;
      cmd_done    <= 1'b0;
      cmd_rdata   <= '0;
      cmd_status  <= 2'b00;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= 4'b0000;
      wb_we_o     <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
    end else begin
      cmd_done <= term_s;
      if (term_s) begin
        cmd_status <= term_status_s;
      end
      // Only ack yields an OK termination, so this captures successful reads only.
      if (term_s && (term_status_s == STS_OK) && !wb_we_o) begin
        cmd_rdata <= wb_dat_i;
      end
      case (state_r)
        ST_IDLE: begin
          if (cmd_start) begin
            wb_adr_o    <= cmd_adr;
            wb_dat_o    <= cmd_dat;
            wb_sel_o    <= cmd_sel;
            wb_we_o     <= cmd_we;
            wb_cyc_o    <= 1'b1;
            wb_stb_o    <= 1'b1;
            retry_cnt_r <= 4'd0;
            tmo_cnt_r   <= 8'd0;
            cmd_busy    <= 1'b1;
            state_r     <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (term_s) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            cmd_busy <= 1'b0;
            state_r  <= ST_IDLE;
          end else if (backoff_s) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            retry_cnt_r <= retry_cnt_r + 4'd1;
            gap_cnt_r   <= 4'd0;
            state_r     <= ST_BACKOFF;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end
        end
        ST_BACKOFF: begin
          if (gap_cnt_r == GAP_LAST) begin
            wb_cyc_o  <= 1'b1;
            wb_stb_o  <= 1'b1;
            tmo_cnt_r <= 8'd0;
            state_r   <= ST_BUS;
          end else begin
            gap_cnt_r <= gap_cnt_r + 4'd1;
          end
        end
        default: begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          cmd_busy <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_dsp_master_interface.sv
// Self-checking bench for wb_dsp_master_interface: directed scenarios plus
// randomized commands against a slave with scripted per-attempt responses.
module tb_wb_dsp_master_interface;

  localparam int TIMEOUT   = 255;
  localparam int MAX_RETRY = 3;
  localparam int RETRY_GAP = 2;
  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_RTY  = 2;
  localparam int K_NONE = 3;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic        cmd_start, cmd_we;
  logic [7:0]  cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        cmd_busy, cmd_done;
  logic [31:0] cmd_rdata;
  logic [1:0]  cmd_status;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i, wb_rty_i;

  wb_dsp_master_interface #(
    .dw(32), .aw(8), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .RETRY_GAP(RETRY_GAP)
  ) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .cmd_start(cmd_start), .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .cmd_sel(cmd_sel), .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_rdata(cmd_rdata),
    .cmd_status(cmd_status), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o),
    .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i)
  );

  always #5 wb_clk = ~wb_clk;

  int checks = 0;
  int errors = 0;

  // Slave memory and the scripted response for each attempt of the next command.
  logic [31:0] mem [256];
  int kind_q[$];
  int wait_q[$];

  // Reference expectations for the next command.
  int          exp_bursts[$];
  int          exp_gaps[$];
  logic [1:0]  exp_status;
  int          exp_done_cyc;
  logic [31:0] exp_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Outcome of a command from the attempt script: each attempt lasts wait+1 stb
  // cycles (or TIMEOUT if the slave stays silent that long), retries are separated
  // by RETRY_GAP idle cycles, and done follows the last stb cycle.
  function automatic void model(input bit we, input logic [7:0] adr);
    int t = 1;
    int k;
    int w;
    int len;
    bit silent;
    exp_bursts.delete();
    exp_gaps.delete();
    exp_status = 2'b11;
    for (int a = 0; a <= MAX_RETRY; a++) begin
      k = (a < kind_q.size()) ? kind_q[a] : K_NONE;
      w = (a < wait_q.size()) ? wait_q[a] : 0;
      silent = (k == K_NONE) || (w + 1 > TIMEOUT);
      len = silent ? TIMEOUT : w + 1;
      exp_bursts.push_back(len);
      t += len;
      if (silent) begin exp_status = 2'b11; break; end
      if (k == K_ACK) begin
        exp_status = 2'b00;
        if (!we) exp_rdata = mem[adr];
        break;
      end
      if (k == K_ERR) begin exp_status = 2'b01; break; end
      if (a == MAX_RETRY) begin exp_status = 2'b10; break; end
      t += RETRY_GAP;
      exp_gaps.push_back(RETRY_GAP);
    end
    exp_done_cyc = t;
  endfunction

  // Issue a command in the current cycle (cycle 0), play the slave, and return
  // in the done cycle so a following call starts back-to-back.
  task automatic run_cmd(input string tag, input bit we, input logic [7:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         input bit poke, output int done_cyc);
    int cyc = 0;
    int att = -1;
    int cnt = 0;
    int cur = 0;
    int gap = 0;
    int hold_bad = 0;
    int k;
    int w;
    bit prev_stb = 1'b0;
    bit busy_at_done = 1'b1;
    logic [1:0]  st = 2'bxx;
    logic [31:0] rd = 32'hx;
    int bursts[$];
    int gaps[$];
    done_cyc = -1;
    model(we, adr);
    cmd_start = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    while (done_cyc < 0 && cyc < 3000) begin
      @(posedge wb_clk); #1;
      cyc++;
      cmd_start = 1'b0;
      if (poke && cyc == 1) begin
        cmd_start = 1'b1; cmd_we = ~we; cmd_adr = ~adr; cmd_dat = ~dat; cmd_sel = ~sel;
      end
      if (wb_cyc_o !== wb_stb_o) hold_bad++;
      if (wb_cti_o !== 3'b000 || wb_bte_o !== 2'b00) hold_bad++;
      if (wb_stb_o && (wb_adr_o !== adr || wb_dat_o !== dat || wb_sel_o !== sel || wb_we_o !== we))
        hold_bad++;
      if (wb_stb_o && !prev_stb) begin
        if (att >= 0) gaps.push_back(gap);
        att++; cnt = 0; cur = 0;
      end
      if (!wb_stb_o && prev_stb) begin bursts.push_back(cur); gap = 0; end
      if (wb_stb_o) begin cur++; cnt++; end else gap++;
      prev_stb = wb_stb_o;
      if (cmd_done) begin
        done_cyc = cyc; st = cmd_status; rd = cmd_rdata; busy_at_done = cmd_busy;
      end
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = $urandom;
      if (wb_stb_o && done_cyc < 0) begin
        k = (att < kind_q.size()) ? kind_q[att] : K_NONE;
        w = (att < wait_q.size()) ? wait_q[att] : 0;
        if (k != K_NONE && cnt == w + 1) begin
          if (k == K_ACK) begin
            wb_ack_i = 1'b1;
            if (we) begin
              for (int b = 0; b < 4; b++)
                if (sel[b]) mem[adr][8*b +: 8] = dat[8*b +: 8];
            end else begin
              wb_dat_i = mem[adr];
            end
          end else if (k == K_ERR) begin
            wb_err_i = 1'b1;
          end else begin
            wb_rty_i = 1'b1;
          end
        end
      end
    end
    chk({tag, ".finished"}, 32'(done_cyc >= 0), 32'd1);
    chk({tag, ".done_cycle"}, 32'(done_cyc), 32'(exp_done_cyc));
    chk({tag, ".status"}, 32'(st), 32'(exp_status));
    chk({tag, ".busy_at_done"}, 32'(busy_at_done), 32'd0);
    chk({tag, ".rdata"}, rd, exp_rdata);
    chk({tag, ".hold_bad"}, 32'(hold_bad), 32'd0);
    chk({tag, ".n_bursts"}, 32'(bursts.size()), 32'(exp_bursts.size()));
    for (int i = 0; i < exp_bursts.size(); i++)
      chk({tag, ".burst_len"}, 32'((i < bursts.size()) ? bursts[i] : -1), 32'(exp_bursts[i]));
    chk({tag, ".n_gaps"}, 32'(gaps.size()), 32'(exp_gaps.size()));
    for (int i = 0; i < exp_gaps.size(); i++)
      chk({tag, ".gap_len"}, 32'((i < gaps.size()) ? gaps[i] : -1), 32'(exp_gaps[i]));
  endtask

  // One cycle with no command: the previous done must not repeat.
  task automatic idle_check(input string tag);
    @(posedge wb_clk); #1;
    chk({tag, ".single_done"}, 32'(cmd_done), 32'd0);
  endtask

  initial begin
    int dc;
    int r;
    int extra_done;
    bit we;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    wb_rst = 1'b1; cmd_start = 1'b0; cmd_we = 1'b0; cmd_adr = 8'h00; cmd_dat = 32'h0;
    cmd_sel = 4'h0; wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    repeat (3) @(posedge wb_clk);
    #1 wb_rst = 1'b0;
    exp_rdata = 32'h0;

    // Reset state
    chk("rst.ctrl", {26'd0, cmd_busy, cmd_done, cmd_status, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("rst.rdata", cmd_rdata, 32'h0);
    chk("rst.adr_we_sel", {19'd0, wb_adr_o, wb_we_o, wb_sel_o}, 32'd0);
    chk("rst.dat", wb_dat_o, 32'h0);
    chk("rst.cti_bte", {27'd0, wb_cti_o, wb_bte_o}, 32'd0);

    // Write with one-cycle-late ack, then read it back
    kind_q = '{K_ACK}; wait_q = '{1};
    run_cmd("wr04", 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 1'b0, dc);
    chk("wr04.latency", 32'(dc), 32'd3);
    idle_check("wr04");
    kind_q = '{K_ACK}; wait_q = '{0};
    run_cmd("rd04", 1'b0, 8'h04, 32'h0, 4'hF, 1'b0, dc);
    chk("rd04.value", cmd_rdata, 32'hDEADBEEF);
    idle_check("rd04");

    // Read with 5 wait states
    mem[8] = 32'h12345678;
    kind_q = '{K_ACK}; wait_q = '{5};
    run_cmd("rd08", 1'b0, 8'h08, 32'h0, 4'hF, 1'b0, dc);
    chk("rd08.value", cmd_rdata, 32'h12345678);
    idle_check("rd08");

    // Bus error keeps previous read data
    kind_q = '{K_ERR}; wait_q = '{2};
    run_cmd("err", 1'b0, 8'h08, 32'h0, 4'hF, 1'b0, dc);
    chk("err.keep_rdata", cmd_rdata, 32'h12345678);
    idle_check("err");

    // Retries exhausted, then rty twice followed by ack
    kind_q = '{K_RTY, K_RTY, K_RTY, K_RTY}; wait_q = '{0, 1, 0, 2};
    run_cmd("rty4", 1'b1, 8'h10, 32'hA5A5A5A5, 4'h3, 1'b0, dc);
    chk("rty4.status", 32'(cmd_status), 32'd2);
    idle_check("rty4");
    kind_q = '{K_RTY, K_RTY, K_ACK}; wait_q = '{1, 0, 3};
    run_cmd("rty2ack", 1'b0, 8'h10, 32'h0, 4'hF, 1'b0, dc);
    chk("rty2ack.status", 32'(cmd_status), 32'd0);
    idle_check("rty2ack");

    // Silent slave times out; an ack on the last stb cycle wins
    kind_q = '{K_NONE}; wait_q = '{0};
    run_cmd("tmo", 1'b0, 8'h20, 32'h0, 4'hF, 1'b0, dc);
    chk("tmo.latency", 32'(dc), 32'd256);
    chk("tmo.status", 32'(cmd_status), 32'd3);
    idle_check("tmo");
    kind_q = '{K_ACK}; wait_q = '{254};
    run_cmd("ack255", 1'b0, 8'h20, 32'h0, 4'hF, 1'b0, dc);
    chk("ack255.latency", 32'(dc), 32'd256);
    chk("ack255.status", 32'(cmd_status), 32'd0);
    idle_check("ack255");

    // Reset during BUS: cyc/stb drop, no done pulse
    cmd_start = 1'b1; cmd_we = 1'b0; cmd_adr = 8'h30; cmd_sel = 4'hF;
    @(posedge wb_clk); #1 cmd_start = 1'b0;
    repeat (4) @(posedge wb_clk);
    #1 chk("rstbus.in_bus", 32'(wb_stb_o), 32'd1);
    wb_rst = 1'b1;
    @(posedge wb_clk); #1 wb_rst = 1'b0;
    chk("rstbus.cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("rstbus.busy_done", {30'd0, cmd_busy, cmd_done}, 32'd0);
    extra_done = 0;
    repeat (3) begin
      @(posedge wb_clk); #1;
      if (cmd_done) extra_done++;
    end
    chk("rstbus.no_done", 32'(extra_done), 32'd0);
    exp_rdata = 32'h0;

    // Start while busy is ignored
    kind_q = '{K_ACK}; wait_q = '{3};
    run_cmd("poke", 1'b1, 8'h05, 32'h0BADF00D, 4'h5, 1'b1, dc);
    idle_check("poke");

    // Back-to-back: second start lands in the done cycle of the first
    kind_q = '{K_ACK}; wait_q = '{0};
    run_cmd("b2b_a", 1'b1, 8'h06, 32'hCAFEF00D, 4'hF, 1'b0, dc);
    kind_q = '{K_ACK}; wait_q = '{2};
    run_cmd("b2b_b", 1'b0, 8'h06, 32'h0, 4'hF, 1'b0, dc);
    chk("b2b_b.value", cmd_rdata, 32'hCAFEF00D);
    idle_check("b2b");

    // Randomized commands against the reference model
    for (int n = 0; n < 25; n++) begin
      kind_q.delete(); wait_q.delete();
      for (int a = 0; a <= MAX_RETRY; a++) begin
        r = $urandom_range(0, 19);
        kind_q.push_back(r < 10 ? K_ACK : r < 13 ? K_ERR : r < 19 ? K_RTY : K_NONE);
        wait_q.push_back($urandom_range(0, 6));
        if (kind_q[a] != K_RTY) break;
      end
      we  = 1'($urandom_range(0, 1));
      adr = 8'($urandom_range(0, 7));
      dat = $urandom;
      sel = 4'($urandom_range(0, 15));
      run_cmd("rand", we, adr, dat, sel, 1'($urandom_range(0, 3) == 0), dc);
      if ($urandom_range(0, 2) != 0) idle_check("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
